// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_SEQ  = 3'd1,
    PC_PRED = 3'd2,
    PC_RAS  = 3'd3,
    PC_EXE  = 3'd4,
    PC_TRAP = 3'd5
  } pc_sel_e;

  localparam int          ILEN_BYTES      = 4;
  localparam logic [31:0] PC_RESET_VECTOR = 32'hFFFF_F000;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return address stack with saturating count; the oldest entry is
// overwritten on overflow, and push+pop together replaces the top in place.
module return_addr_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] entries_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   top_idx_s;
  logic [PW-1:0]   wr_idx_s;
  logic            wr_en_s;

  assign top_idx_s = ptr_q - PW'(1);
  assign top       = entries_q[top_idx_s];
  assign empty     = (count_q == '0);

  always_comb begin
    ptr_d    = ptr_q;
    count_d  = count_q;
    wr_en_s  = 1'b0;
    wr_idx_s = ptr_q;
    if (clear) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (push && pop && !empty) begin
      wr_en_s  = 1'b1;
      wr_idx_s = top_idx_s;
    end else if (push) begin
      wr_en_s = 1'b1;
      ptr_d   = ptr_q + PW'(1);
      if (count_q != CW'(DEPTH)) begin
        count_d = count_q + CW'(1);
      end else begin
        count_d = count_q;
      end
    end else if (pop && !empty) begin
      ptr_d   = top_idx_s;
      count_d = count_q - CW'(1);
    end else begin
      ptr_d   = ptr_q;
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      entries_q[wr_idx_s] <= push_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: trap > exe > RAS > predictor > sequential > hold.
// Return address stack is built only when PC_GEN_RAS_EN is defined.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            trap_redirect,
  input  logic [XLEN-1:0] trap_target,
  input  logic            exe_redirect,
  input  logic [XLEN-1:0] exe_target,
  input  logic            pred_taken_if1,
  input  logic [XLEN-1:0] pred_target_if1,
  input  logic            call_if1,
  input  logic            ret_if1,
  output logic [XLEN-1:0] current_pc_if1,
  output logic [XLEN-1:0] next_pc_if1,
  output pc_sel_e         pc_sel_if1,
  output logic            ras_hit_if1
);

  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] seq_pc_s;
  logic [XLEN-1:0] ras_top_s;
  logic            ras_hit_s;
  pc_sel_e         sel_s;

  assign seq_pc_s = pc_q + XLEN'(ILEN_BYTES);

`ifdef PC_GEN_RAS_EN
  logic ras_op_s, ras_push_s, ras_pop_s, ras_empty_s;

  // A redirect squashes the fetch that raised call/ret.
  assign ras_op_s   = en & ~trap_redirect & ~exe_redirect;
  assign ras_push_s = ras_op_s & call_if1;
  assign ras_pop_s  = ras_op_s & ret_if1;
  assign ras_hit_s  = ras_pop_s & ~ras_empty_s;

  return_addr_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .clear     (trap_redirect),
    .push_data (seq_pc_s),
    .top       (ras_top_s),
    .empty     (ras_empty_s)
  );
`else
  logic unused_ras_s;

  assign unused_ras_s = call_if1 ^ ret_if1;
  assign ras_hit_s    = 1'b0;
  assign ras_top_s    = '0;
`endif

  always_comb begin
    pc_d  = pc_q;
    sel_s = PC_HOLD;
    if (trap_redirect) begin
      pc_d  = align(trap_target);
      sel_s = PC_TRAP;
    end else if (exe_redirect) begin
      pc_d  = align(exe_target);
      sel_s = PC_EXE;
    end else if (ras_hit_s) begin
      pc_d  = align(ras_top_s);
      sel_s = PC_RAS;
    end else if (en && pred_taken_if1) begin
      pc_d  = align(pred_target_if1);
      sel_s = PC_PRED;
    end else if (en) begin
      pc_d  = seq_pc_s;
      sel_s = PC_SEQ;
    end else begin
      pc_d  = pc_q;
      sel_s = PC_HOLD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign current_pc_if1 = pc_q;
  assign next_pc_if1    = pc_d;
  assign pc_sel_if1     = sel_s;
  assign ras_hit_if1    = ras_hit_s;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; RAS scenarios run when PC_GEN_RAS_EN is defined.
module tb_pc_gen;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        trap_redirect;
  logic [31:0] trap_target;
  logic        exe_redirect;
  logic [31:0] exe_target;
  logic        pred_taken_if1;
  logic [31:0] pred_target_if1;
  logic        call_if1;
  logic        ret_if1;
  logic [31:0] current_pc_if1;
  logic [31:0] next_pc_if1;
  logic [2:0]  pc_sel_if1;
  logic        ras_hit_if1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .en              (en),
    .trap_redirect   (trap_redirect),
    .trap_target     (trap_target),
    .exe_redirect    (exe_redirect),
    .exe_target      (exe_target),
    .pred_taken_if1  (pred_taken_if1),
    .pred_target_if1 (pred_target_if1),
    .call_if1        (call_if1),
    .ret_if1         (ret_if1),
    .current_pc_if1  (current_pc_if1),
    .next_pc_if1     (next_pc_if1),
    .pc_sel_if1      (pc_sel_if1),
    .ras_hit_if1     (ras_hit_if1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    exe_redirect = 1'b1;
    exe_target   = addr;
    tick();
    exe_redirect = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; en = 1'b0;
    trap_redirect = 1'b0; trap_target = '0;
    exe_redirect = 1'b0; exe_target = '0;
    pred_taken_if1 = 1'b0; pred_target_if1 = '0;
    call_if1 = 1'b0; ret_if1 = 1'b0;

    tick(); tick();
    check_eq("reset_pc", current_pc_if1, 32'hFFFF_F000);
    check_eq("reset_next_hold", next_pc_if1, 32'hFFFF_F000);
    check_eq("reset_sel", 32'(pc_sel_if1), 32'(PC_HOLD));

    reset_n = 1'b1; en = 1'b1;
    #1 check_eq("seq_next", next_pc_if1, 32'hFFFF_F004);
    check_eq("seq_sel", 32'(pc_sel_if1), 32'(PC_SEQ));
    tick();
    check_eq("seq_pc1", current_pc_if1, 32'hFFFF_F004);
    tick();
    check_eq("seq_pc2", current_pc_if1, 32'hFFFF_F008);

    // Stall does not drop a redirect; target low bits are cleared.
    en = 1'b0; exe_redirect = 1'b1; exe_target = 32'h0000_1002;
    #1 check_eq("stall_exe_sel", 32'(pc_sel_if1), 32'(PC_EXE));
    tick();
    exe_redirect = 1'b0;
    check_eq("stall_exe_pc", current_pc_if1, 32'h0000_1000);
    tick();
    check_eq("stall_hold_pc", current_pc_if1, 32'h0000_1000);
    check_eq("stall_hold_sel", 32'(pc_sel_if1), 32'(PC_HOLD));

    trap_redirect = 1'b1; trap_target = 32'h8000_0000;
    exe_redirect = 1'b1; exe_target = 32'h0000_2000;
    #1 check_eq("trap_sel", 32'(pc_sel_if1), 32'(PC_TRAP));
    tick();
    trap_redirect = 1'b0; exe_redirect = 1'b0;
    check_eq("trap_pc", current_pc_if1, 32'h8000_0000);

    goto_pc(32'hFFFF_FFFC);
    check_eq("wrap_start", current_pc_if1, 32'hFFFF_FFFC);
    en = 1'b1;
    #1 check_eq("wrap_next", next_pc_if1, 32'h0000_0000);
    tick();
    check_eq("wrap_pc", current_pc_if1, 32'h0000_0000);

    pred_taken_if1 = 1'b1; pred_target_if1 = 32'h0000_0301;
    #1 check_eq("pred_next", next_pc_if1, 32'h0000_0300);
    check_eq("pred_sel", 32'(pc_sel_if1), 32'(PC_PRED));
    tick();
    pred_taken_if1 = 1'b0;
    check_eq("pred_pc", current_pc_if1, 32'h0000_0300);

`ifdef PC_GEN_RAS_EN
    goto_pc(32'h0000_0100);
    call_if1 = 1'b1;
    #1 check_eq("call_next", next_pc_if1, 32'h0000_0104);
    tick();
    call_if1 = 1'b0;
    goto_pc(32'h0000_0200);
    ret_if1 = 1'b1;
    #1 check_eq("ret_hit", 32'(ras_hit_if1), 32'd1);
    check_eq("ret_next", next_pc_if1, 32'h0000_0104);
    check_eq("ret_sel", 32'(pc_sel_if1), 32'(PC_RAS));
    tick();
    pred_taken_if1 = 1'b1; pred_target_if1 = 32'h0000_0300;
    #1 check_eq("ret_empty_hit", 32'(ras_hit_if1), 32'd0);
    check_eq("ret_empty_next", next_pc_if1, 32'h0000_0300);
    tick();
    pred_taken_if1 = 1'b0; ret_if1 = 1'b0;

    goto_pc(32'h0000_1000);
    call_if1 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    call_if1 = 1'b0;
    check_eq("ovf_pc", current_pc_if1, 32'h0000_1014);
    ret_if1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("ovf_hit", 32'(ras_hit_if1), 32'd1);
      check_eq("ovf_next", next_pc_if1, 32'h0000_1014 - 32'(4 * i));
      tick();
    end
    #1 check_eq("ovf_miss_hit", 32'(ras_hit_if1), 32'd0);
    check_eq("ovf_miss_next", next_pc_if1, 32'h0000_100C);
    ret_if1 = 1'b0;
    tick();

    call_if1 = 1'b1; exe_redirect = 1'b1; exe_target = 32'h0000_3000;
    tick();
    call_if1 = 1'b0; exe_redirect = 1'b0; ret_if1 = 1'b1;
    #1 check_eq("squash_hit", 32'(ras_hit_if1), 32'd0);
    check_eq("squash_next", next_pc_if1, 32'h0000_3004);
    ret_if1 = 1'b0;
    tick();
    call_if1 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    call_if1 = 1'b0;
    trap_redirect = 1'b1; trap_target = 32'h0000_4000;
    tick();
    trap_redirect = 1'b0; ret_if1 = 1'b1;
    #1 check_eq("clear_hit", 32'(ras_hit_if1), 32'd0);
    check_eq("clear_next", next_pc_if1, 32'h0000_4004);
    tick();
    ret_if1 = 1'b0;
`else
    goto_pc(32'h0000_0100);
    call_if1 = 1'b1;
    tick();
    call_if1 = 1'b0; ret_if1 = 1'b1;
    #1 check_eq("noras_hit", 32'(ras_hit_if1), 32'd0);
    check_eq("noras_next", next_pc_if1, 32'h0000_0108);
    check_eq("noras_sel", 32'(pc_sel_if1), 32'(PC_SEQ));
    tick();
    ret_if1 = 1'b0;
`endif

    // Reset mid-redirect discards the pending target at once.
    exe_redirect = 1'b1; exe_target = 32'h0000_5000;
    #1 reset_n = 1'b0;
    #1 check_eq("rst_async_pc", current_pc_if1, 32'hFFFF_F000);
    tick();
    check_eq("rst_hold_pc", current_pc_if1, 32'hFFFF_F000);
    exe_redirect = 1'b0; reset_n = 1'b1;
    tick();
    check_eq("rst_release_pc", current_pc_if1, 32'hFFFF_F004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
